// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_param
// Purpose  : Parametrised SPI slave front-end between an external SPI master
//            and a single-port RAM. Deserialises MOSI frames into
//            {cmd[1:0], payload[DATA_W-1:0]} words, and for read-data
//            commands waits (bounded) for RAM data, then serialises it on MISO.
// Ports    : clk, rst         - system clock, synchronous active-high reset
//            SS_n, MOSI       - slave select (active low), serial data in
//            MISO             - serial data out (registered)
//            rx_data/rx_valid - received frame and one-cycle strobe
//            tx_data/tx_valid - read data from RAM and its valid
//            tx_timeout       - one-cycle pulse, RAM data did not arrive
//            frame_abort      - one-cycle pulse, SS_n rose mid-frame
// Options  : SPI_FRAME_ABORT_EN - when defined, frame_abort is driven;
//            otherwise frame_abort is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_param #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_timeout,
    output logic              frame_abort
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TMR_W   = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4,
        WAIT_TX   = 3'd5,
        SEND      = 3'd6,
        DONE      = 3'd7
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_addr_seen;
    logic [DATA_W-1:0] r_shift;
    logic [TMR_W-1:0]  r_timer;
    logic [CNT_W-1:0]  w_idx;

    // Bit position written by the current receive cycle (frame is MSB first).
    assign w_idx = r_cnt - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr_seen <= 1'b0;
            r_shift     <= '0;
            r_timer     <= '0;
            MISO        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_timeout  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_timeout  <= 1'b0;
            frame_abort <= 1'b0;

            case (r_state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (!SS_n) begin
                        r_state <= CHK_CMD;
                    end
                end

                CHK_CMD: begin
                    // Deselect here is harmless: no frame bits received yet.
                    if (SS_n) begin
                        r_state <= IDLE;
                        MISO    <= 1'b0;
                    end else begin
                        r_cnt <= CNT_W'(FRAME_W);
                        if (!MOSI) begin
                            r_state <= WRITE;
                        end else if (!r_addr_seen) begin
                            r_state <= READ_ADD;
                        end else begin
                            r_state <= READ_DATA;
                        end
                    end
                end

                WRITE, READ_ADD, READ_DATA: begin
                    if (SS_n) begin
                        // Partial bits stay in rx_data; addr_seen untouched.
                        r_state <= IDLE;
                        MISO    <= 1'b0;
`ifdef SPI_FRAME_ABORT_EN
                        if (r_cnt != '0) begin
                            frame_abort <= 1'b1;
                        end
`endif
                    end else if (r_cnt != '0) begin
                        rx_data[w_idx] <= MOSI;
                        r_cnt          <= w_idx;
                    end else begin
                        rx_valid <= 1'b1;
                        case (r_state)
                            WRITE: begin
                                r_addr_seen <= 1'b0;
                                r_state     <= DONE;
                            end
                            READ_ADD: begin
                                r_addr_seen <= 1'b1;
                                r_state     <= DONE;
                            end
                            default: begin
                                if (rx_data[DATA_W+1 -: 2] == 2'b11) begin
                                    r_timer <= '0;
                                    r_state <= WAIT_TX;
                                end else begin
                                    r_state <= DONE;
                                end
                            end
                        endcase
                    end
                end

                WAIT_TX: begin
                    if (SS_n) begin
                        r_state <= IDLE;
                        MISO    <= 1'b0;
`ifdef SPI_FRAME_ABORT_EN
                        frame_abort <= 1'b1;
`endif
                    end else if (tx_valid) begin
                        // MSB goes straight out; the rest is pre-shifted so
                        // SEND always drives the buffer MSB.
                        MISO    <= tx_data[DATA_W-1];
                        r_shift <= {tx_data[DATA_W-2:0], 1'b0};
                        r_cnt   <= CNT_W'(DATA_W - 1);
                        r_state <= SEND;
                    end else if ((TX_TIMEOUT != 0) &&
                                 (r_timer == TMR_W'(TX_TIMEOUT - 1))) begin
                        tx_timeout  <= 1'b1;
                        r_addr_seen <= 1'b0;
                        MISO        <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        // With TX_TIMEOUT=0 the timer just wraps unobserved.
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end

                SEND: begin
                    if (SS_n) begin
                        r_state <= IDLE;
                        MISO    <= 1'b0;
`ifdef SPI_FRAME_ABORT_EN
                        frame_abort <= 1'b1;
`endif
                    end else if (r_cnt != '0) begin
                        MISO    <= r_shift[DATA_W-1];
                        r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                        r_cnt   <= w_idx;
                    end else begin
                        MISO        <= 1'b0;
                        r_addr_seen <= 1'b0;
                        r_state     <= DONE;
                    end
                end

                DONE: begin
                    MISO <= 1'b0;
                    if (SS_n) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    MISO    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_param
// Purpose  : Directed self-checking bench for spi_slave_param. Instance A uses
//            DATA_W=8/TX_TIMEOUT=4, instance B uses DATA_W=16/TX_TIMEOUT=0.
//            Expected rx words are queued when a frame is driven and popped
//            when the DUT strobes rx_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_param;

`ifdef SPI_FRAME_ABORT_EN
    localparam logic ABORT_EN = 1'b1;
`else
    localparam logic ABORT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_ss = 1'b1, a_mosi = 1'b0, a_miso;
    logic [9:0]  a_rx_data;
    logic        a_rx_valid;
    logic [7:0]  a_tx_data = '0;
    logic        a_tx_valid = 1'b0, a_tx_timeout, a_frame_abort;

    logic        b_ss = 1'b1, b_mosi = 1'b0, b_miso;
    logic [17:0] b_rx_data;
    logic        b_rx_valid;
    logic [15:0] b_tx_data = '0;
    logic        b_tx_valid = 1'b0, b_tx_timeout, b_frame_abort;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int a_rx_cyc = -1;
    int b_rx_cyc = -1;
    logic [17:0] qa[$];
    logic [17:0] qb[$];

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .SS_n(a_ss), .MOSI(a_mosi), .MISO(a_miso),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .tx_data(a_tx_data),
        .tx_valid(a_tx_valid), .tx_timeout(a_tx_timeout),
        .frame_abort(a_frame_abort)
    );

    spi_slave_param #(.DATA_W(16), .TX_TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .SS_n(b_ss), .MOSI(b_mosi), .MISO(b_miso),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .tx_data(b_tx_data),
        .tx_valid(b_tx_valid), .tx_timeout(b_tx_timeout),
        .frame_abort(b_frame_abort)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge. Any rx_valid
    // must match the oldest queued expected word.
    task automatic cycle();
        logic [17:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (a_rx_valid === 1'b1) begin
            check("a_rx_expected", 32'(qa.size() > 0), 32'd1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("a_rx_data", {22'd0, a_rx_data}, {14'd0, e});
                a_rx_cyc = cyc;
            end
        end
        if (b_rx_valid === 1'b1) begin
            check("b_rx_expected", 32'(qb.size() > 0), 32'd1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("b_rx_data", {14'd0, b_rx_data}, {14'd0, e});
                b_rx_cyc = cyc;
            end
        end
    endtask

    task automatic set_in(input bit sel, input logic ss, input logic mosi);
        if (sel) begin b_ss = ss; b_mosi = mosi; end
        else     begin a_ss = ss; a_mosi = mosi; end
    endtask

    task automatic set_tx(input bit sel, input logic v, input logic [15:0] d);
        if (sel) begin b_tx_valid = v; b_tx_data = d; end
        else     begin a_tx_valid = v; a_tx_data = d[7:0]; end
    endtask

    function automatic logic miso_of(input bit sel);
        return sel ? b_miso : a_miso;
    endfunction

    function automatic logic timeout_of(input bit sel);
        return sel ? b_tx_timeout : a_tx_timeout;
    endfunction

    // Full frame: SS_n low, direction bit, n frame bits MSB first, then the
    // rx_valid cycle. SS_n is left low on return.
    task automatic frame(input bit sel, input logic dir,
                         input logic [17:0] bits, input int n);
        int start;
        if (sel) begin qb.push_back(bits); b_rx_cyc = -1; end
        else     begin qa.push_back(bits); a_rx_cyc = -1; end
        set_in(sel, 1'b0, 1'b0);
        cycle();
        start = cyc;
        set_in(sel, 1'b0, dir);
        cycle();
        for (int i = n - 1; i >= 0; i--) begin
            set_in(sel, 1'b0, bits[i]);
            cycle();
        end
        set_in(sel, 1'b0, 1'b0);
        cycle();
        check(sel ? "b_rx_latency" : "a_rx_latency",
              sel ? b_rx_cyc : a_rx_cyc, start + n + 2);
    endtask

    task automatic deselect(input bit sel);
        set_in(sel, 1'b1, 1'b0);
        cycle();
    endtask

    // tx_valid for one cycle, then scramble tx_data and expect n MISO bits
    // MSB first followed by MISO=0.
    task automatic send_check(input bit sel, input logic [15:0] d, input int n);
        set_tx(sel, 1'b1, d);
        cycle();
        set_tx(sel, 1'b0, ~d);
        for (int i = n - 1; i >= 0; i--) begin
            check("miso_bit", miso_of(sel), d[i]);
            cycle();
        end
        check("miso_after", miso_of(sel), 1'b0);
    endtask

    // A cmd=11 read frame on instance A that must decode as READ_ADD: even
    // with tx_valid held high nothing is shifted out and no timeout occurs.
    task automatic chk_read_add(input string tag);
        frame(1'b0, 1'b1, 18'h3A5, 10);
        set_tx(1'b0, 1'b1, 16'h00FF);
        for (int k = 0; k < 6; k++) begin
            cycle();
            check(tag, a_miso, 1'b0);
        end
        check({tag, "_to"}, a_tx_timeout, 1'b0);
        set_tx(1'b0, 1'b0, 16'h0000);
        deselect(1'b0);
    endtask

    initial begin
        // Reset state
        cycle();
        cycle();
        check("rst_a_miso", a_miso, 1'b0);
        check("rst_a_rx_data", {22'd0, a_rx_data}, 32'd0);
        check("rst_a_rx_valid", a_rx_valid, 1'b0);
        check("rst_a_tx_timeout", a_tx_timeout, 1'b0);
        check("rst_a_frame_abort", a_frame_abort, 1'b0);
        check("rst_b_miso", b_miso, 1'b0);
        check("rst_b_rx_data", {14'd0, b_rx_data}, 32'd0);
        rst = 1'b0;
        cycle();

        // Write frame
        frame(1'b0, 1'b0, 18'h0A5, 10);
        deselect(1'b0);

        // Read address then read data, tx_valid two cycles after rx_valid
        frame(1'b0, 1'b1, 18'h233, 10);
        deselect(1'b0);
        frame(1'b0, 1'b1, 18'h300, 10);
        cycle();
        send_check(1'b0, 16'h00C3, 8);
        deselect(1'b0);

        // addr_seen cleared after SEND: cmd 11 must be READ_ADD
        chk_read_add("rd_add_after_send");

        // Timeout exactly 4 cycles after WAIT_TX entry, single-cycle pulse
        frame(1'b0, 1'b1, 18'h3F0, 10);
        for (int k = 1; k <= 5; k++) begin
            cycle();
            check("timeout_pulse", a_tx_timeout, (k == 4) ? 1'b1 : 1'b0);
            check("timeout_miso", a_miso, 1'b0);
        end
        deselect(1'b0);
        chk_read_add("rd_add_after_timeout");

        // tx_valid on the final timeout cycle wins, then reset mid-SEND
        frame(1'b0, 1'b1, 18'h30F, 10);
        for (int k = 1; k <= 3; k++) begin
            cycle();
            check("no_timeout_yet", a_tx_timeout, 1'b0);
        end
        set_tx(1'b0, 1'b1, 16'h00A5);
        cycle();
        check("valid_wins_to", a_tx_timeout, 1'b0);
        check("valid_wins_bit7", a_miso, 1'b1);
        set_tx(1'b0, 1'b0, 16'h005A);
        cycle();
        check("send_bit6", a_miso, 1'b0);
        cycle();
        check("send_bit5", a_miso, 1'b1);
        rst  = 1'b1;
        a_ss = 1'b1;
        cycle();
        check("rst_send_miso", a_miso, 1'b0);
        check("rst_send_rx_valid", a_rx_valid, 1'b0);
        check("rst_send_to", a_tx_timeout, 1'b0);
        rst = 1'b0;
        cycle();
        check("rst_send_idle_miso", a_miso, 1'b0);
        chk_read_add("rd_add_after_reset");

        // Abort after 5 of 10 WRITE bits
        set_in(1'b0, 1'b0, 1'b0);
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b0, 1'b1);
            cycle();
        end
        set_in(1'b0, 1'b1, 1'b0);
        cycle();
        check("abort_pulse", a_frame_abort, ABORT_EN);
        check("abort_miso", a_miso, 1'b0);
        check("abort_partial", {27'd0, a_rx_data[9:5]}, 32'h1F);
        cycle();
        check("abort_pulse_end", a_frame_abort, 1'b0);
        frame(1'b0, 1'b0, 18'h2C3, 10);
        deselect(1'b0);

        // Abort during WAIT_TX (addr_seen was cleared by the write above)
        frame(1'b0, 1'b1, 18'h311, 10);
        deselect(1'b0);
        frame(1'b0, 1'b1, 18'h322, 10);
        cycle();
        set_in(1'b0, 1'b1, 1'b0);
        cycle();
        check("abort_wait_pulse", a_frame_abort, ABORT_EN);
        check("abort_wait_to", a_tx_timeout, 1'b0);
        cycle();

        // DATA_W=16, unbounded wait
        frame(1'b1, 1'b0, 18'h2BEEF, 18);
        deselect(1'b1);
        frame(1'b1, 1'b1, 18'h20012, 18);
        deselect(1'b1);
        frame(1'b1, 1'b1, 18'h30000, 18);
        for (int k = 0; k < 20; k++) begin
            cycle();
            check("b_wait_to", timeout_of(1'b1), 1'b0);
        end
        check("b_wait_miso", b_miso, 1'b0);
        send_check(1'b1, 16'h8001, 16);
        deselect(1'b1);
        check("b_no_abort", b_frame_abort, 1'b0);

        check("qa_drained", qa.size(), 32'd0);
        check("qb_drained", qb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
